// File: rtl/gt1_pkg.sv
// Shared types and constants for the GT1 program image loader.
package gt1_pkg;

    // Parser states, in stream order
    typedef enum logic [2:0] {
        IDLE,
        SEG_HI,
        SEG_LO,
        SEG_SIZE,
        DATA,
        START_HI,
        START_LO,
        DONE
    } gt1_state_t;

    // A zero segment-high byte (after the first segment) marks the start address
    localparam logic [7:0]  GT1_TERMINATOR = 8'h00;
    // A size byte of zero stands for a full page
    localparam int unsigned GT1_PAGE_SIZE  = 256;
    // Byte counter width, wide enough to hold GT1_PAGE_SIZE
    localparam int unsigned GT1_CNT_W      = 9;

    // True when a 16-bit GT1 address falls inside a 2**aw byte RAM
    function automatic logic gt1_in_range(input logic [15:0] addr, input int unsigned aw);
        if (aw >= 32'd16) begin
            return 1'b1;
        end
        return ((32'(addr) >> aw) == 32'd0);
    endfunction

endpackage

// File: rtl/gt1_loader_if.sv
// Bus bundle between the HPS download channel, the loader and main RAM.
//   dl_active/dl_wr/dl_data : download stream in
//   ram_wren/ram_cs/ram_address/ram_data : RAM write port out
//   cpu_hold/exec_addr/exec_valid/load_err : CPU control and status out
// master = loader side, slave = environment (HPS + RAM + CPU) side.
interface gt1_loader_if #(
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  dl_active;
    logic                  dl_wr;
    logic [7:0]            dl_data;
    logic                  ram_wren;
    logic                  ram_cs;
    logic [ADDR_WIDTH-1:0] ram_address;
    logic [DATA_WIDTH-1:0] ram_data;
    logic                  cpu_hold;
    logic [15:0]           exec_addr;
    logic                  exec_valid;
    logic                  load_err;

    modport master (
        input  dl_active, dl_wr, dl_data,
        output ram_wren, ram_cs, ram_address, ram_data,
        output cpu_hold, exec_addr, exec_valid, load_err
    );

    modport slave (
        output dl_active, dl_wr, dl_data,
        input  ram_wren, ram_cs, ram_address, ram_data,
        input  cpu_hold, exec_addr, exec_valid, load_err
    );
endinterface

// File: rtl/gt1_edge_det.sv
// Rise/fall detector on a level signal, comparing it against its registered
// copy from the previous cycle.
//   i_clk, i_rst : clock, async active-high reset
//   i_level      : level to watch
//   o_rise_c     : combinational, high in the first cycle i_level is 1
//   o_fall_c     : combinational, high in the first cycle i_level is 0
module gt1_edge_det (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_level,
    output logic o_rise_c,
    output logic o_fall_c
);
    logic r_prev;

    // Previous-cycle level; reset low so a level already high after reset reads as a rise
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_level;
        end
    end

    assign o_rise_c = i_level & ~r_prev;
    assign o_fall_c = ~i_level & r_prev;
endmodule

// File: rtl/gt1_loader.sv
// GT1 image loader: parses the HPS download stream into segments, writes
// segment data into main RAM, holds the CPU in reset while loading and
// publishes the start address at the end.
//   clock, reset : system clock, async active-high reset
//   bus (master) : download stream in, RAM write port and CPU status out
module gt1_loader
    import gt1_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic         clock,
    input  logic         reset,
    gt1_loader_if.master bus
);
    gt1_state_t            r_state;
    logic                  r_first_seg;
    logic [7:0]            r_hi;
    logic [7:0]            r_lo;
    logic [GT1_CNT_W-1:0]  r_cnt;
    logic                  r_ram_wren;
    logic [ADDR_WIDTH-1:0] r_ram_address;
    logic [DATA_WIDTH-1:0] r_ram_data;
    logic                  r_cpu_hold;
    logic [15:0]           r_exec_addr;
    logic                  r_exec_valid;
    logic                  r_load_err;

    logic                  w_rise;
    logic                  w_fall;
    logic                  w_take;
    logic [15:0]           w_addr16;
    logic                  w_addr_ok;

    gt1_edge_det u_edge (
        .i_clk    (clock),
        .i_rst    (reset),
        .i_level  (bus.dl_active),
        .o_rise_c (w_rise),
        .o_fall_c (w_fall)
    );

    // A byte is consumed on a strobe while active, except in the rise cycle
    assign w_take    = bus.dl_wr & bus.dl_active & ~w_rise;
    assign w_addr16  = {r_hi, r_lo};
    assign w_addr_ok = gt1_in_range(w_addr16, ADDR_WIDTH);

    // Parser FSM with registered RAM port and status outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_first_seg   <= 1'b1;
            r_hi          <= 8'h00;
            r_lo          <= 8'h00;
            r_cnt         <= '0;
            r_ram_wren    <= 1'b0;
            r_ram_address <= '0;
            r_ram_data    <= '0;
            r_cpu_hold    <= 1'b0;
            r_exec_addr   <= 16'h0000;
            r_exec_valid  <= 1'b0;
            r_load_err    <= 1'b0;
        end else begin
            r_ram_wren <= 1'b0;
            if (w_rise) begin
                // New download (or restart): clear status and hold the CPU
                r_state      <= SEG_HI;
                r_first_seg  <= 1'b1;
                r_cpu_hold   <= 1'b1;
                r_exec_valid <= 1'b0;
                r_load_err   <= 1'b0;
            end else if (w_fall) begin
                // Any write from the previous cycle's byte is already on the port
                r_state    <= IDLE;
                r_cpu_hold <= 1'b0;
                if (r_state == DONE) begin
                    r_exec_valid <= 1'b1;
                end else begin
                    r_exec_valid <= 1'b0;
                    r_load_err   <= 1'b1;
                end
            end else if (w_take) begin
                case (r_state)
                    SEG_HI: begin
                        // Zero page is only a segment address for the first segment
                        if ((bus.dl_data == GT1_TERMINATOR) && !r_first_seg) begin
                            r_state <= START_HI;
                        end else begin
                            r_hi    <= bus.dl_data;
                            r_state <= SEG_LO;
                        end
                    end
                    SEG_LO: begin
                        r_lo    <= bus.dl_data;
                        r_state <= SEG_SIZE;
                    end
                    SEG_SIZE: begin
                        if (bus.dl_data == 8'h00) begin
                            r_cnt <= GT1_CNT_W'(GT1_PAGE_SIZE);
                        end else begin
                            r_cnt <= GT1_CNT_W'(bus.dl_data);
                        end
                        r_state <= DATA;
                    end
                    DATA: begin
                        if (w_addr_ok) begin
                            r_ram_wren    <= 1'b1;
                            r_ram_address <= ADDR_WIDTH'(w_addr16);
                            r_ram_data    <= DATA_WIDTH'(bus.dl_data);
                        end else begin
                            r_load_err <= 1'b1;
                        end
                        // Low byte wraps inside the page; the high byte is fixed
                        r_lo  <= r_lo + 8'd1;
                        r_cnt <= r_cnt - GT1_CNT_W'(1);
                        if (r_cnt == GT1_CNT_W'(1)) begin
                            r_first_seg <= 1'b0;
                            r_state     <= SEG_HI;
                        end
                    end
                    START_HI: begin
                        r_exec_addr[15:8] <= bus.dl_data;
                        r_state           <= START_LO;
                    end
                    START_LO: begin
                        r_exec_addr[7:0] <= bus.dl_data;
                        r_state          <= DONE;
                    end
                    default: begin
                        // IDLE and DONE discard bytes (DONE absorbs HPS padding)
                    end
                endcase
            end
        end
    end

    assign bus.ram_wren    = r_ram_wren;
    assign bus.ram_cs      = r_cpu_hold;
    assign bus.ram_address = r_ram_address;
    assign bus.ram_data    = r_ram_data;
    assign bus.cpu_hold    = r_cpu_hold;
    assign bus.exec_addr   = r_exec_addr;
    assign bus.exec_valid  = r_exec_valid;
    assign bus.load_err    = r_load_err;
endmodule

// File: tb/tb_gt1_loader.sv
// Directed self-checking bench for gt1_loader.
module tb_gt1_loader;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    int unsigned exp_addr[$];
    int unsigned exp_data[$];
    int unsigned exp_cyc[$];
    int unsigned got_addr[$];
    int unsigned got_data[$];
    int unsigned got_cyc[$];

    always #5 clk = ~clk;

    gt1_loader_if #(.ADDR_WIDTH(15), .DATA_WIDTH(8)) bus ();

    gt1_loader #(.ADDR_WIDTH(15), .DATA_WIDTH(8)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Log every RAM write with the index of the clock edge that produced it
    always @(negedge clk) begin
        if (bus.ram_wren === 1'b1) begin
            got_addr.push_back(32'(bus.ram_address));
            got_data.push_back(32'(bus.ram_data));
            got_cyc.push_back(32'(cyc));
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] b);
        bus.dl_wr   = 1'b1;
        bus.dl_data = b;
        tick();
        bus.dl_wr   = 1'b0;
    endtask

    // Byte that must produce a write of itself at addr on the consuming edge
    task automatic put_w(input logic [7:0] b, input logic [15:0] addr);
        exp_addr.push_back(32'(addr));
        exp_data.push_back(32'(b));
        exp_cyc.push_back(32'(cyc + 1));
        put(b);
    endtask

    // Raise dl_active with a strobe in the edge cycle, which must be ignored
    task automatic start_load();
        bus.dl_active = 1'b1;
        put(8'h77);
    endtask

    // Drop dl_active with a strobe in the fall cycle, which must be ignored
    task automatic stop_load(input string tag, input logic exp_valid, input logic exp_err);
        check({tag, "_hold_pre"}, 32'(bus.cpu_hold), 32'd1);
        bus.dl_active = 1'b0;
        put(8'hEE);
        check({tag, "_hold"},  32'(bus.cpu_hold),   32'd0);
        check({tag, "_cs"},    32'(bus.ram_cs),     32'd0);
        check({tag, "_valid"}, 32'(bus.exec_valid), 32'(exp_valid));
        check({tag, "_err"},   32'(bus.load_err),   32'(exp_err));
    endtask

    task automatic verify_writes(input string tag);
        check({tag, "_nwr"}, 32'(got_addr.size()), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size(); i++) begin
            if (i < got_addr.size()) begin
                check($sformatf("%s_a%0d", tag, i), got_addr[i], exp_addr[i]);
                check($sformatf("%s_d%0d", tag, i), got_data[i], exp_data[i]);
                check($sformatf("%s_c%0d", tag, i), got_cyc[i],  exp_cyc[i]);
            end
        end
        exp_addr.delete(); exp_data.delete(); exp_cyc.delete();
        got_addr.delete(); got_data.delete(); got_cyc.delete();
    endtask

    initial begin
        rst           = 1'b1;
        bus.dl_active = 1'b0;
        bus.dl_wr     = 1'b0;
        bus.dl_data   = 8'h00;
        tick();
        check("rst_wren",  32'(bus.ram_wren),    32'd0);
        check("rst_cs",    32'(bus.ram_cs),      32'd0);
        check("rst_hold",  32'(bus.cpu_hold),    32'd0);
        check("rst_exec",  32'(bus.exec_addr),   32'd0);
        check("rst_valid", 32'(bus.exec_valid),  32'd0);
        check("rst_err",   32'(bus.load_err),    32'd0);
        rst = 1'b0;
        tick();

        // Basic image: one segment of three bytes at 0x0200, start 0x0200
        start_load();
        check("t1_hold", 32'(bus.cpu_hold), 32'd1);
        check("t1_cs",   32'(bus.ram_cs),   32'd1);
        put(8'h02); put(8'h00); put(8'h03);
        put_w(8'hAA, 16'h0200); put_w(8'hBB, 16'h0201); put_w(8'hCC, 16'h0202);
        put(8'h00); put(8'h02); put(8'h00);
        check("t1_valid_pre", 32'(bus.exec_valid), 32'd0);
        check("t1_exec",      32'(bus.exec_addr),  32'h0200);
        stop_load("t1", 1'b1, 1'b0);
        verify_writes("t1");

        // Zero-page first segment is data, the next zero is the terminator
        start_load();
        put(8'h00); put(8'h30); put(8'h01);
        put_w(8'h55, 16'h0030);
        put(8'h00); put(8'h08); put(8'h00);
        stop_load("t2", 1'b1, 1'b0);
        check("t2_exec", 32'(bus.exec_addr), 32'h0800);
        verify_writes("t2");

        // Page wrap within a segment, then a full 256-byte page from lo=0x80
        start_load();
        put(8'h05); put(8'hFE); put(8'h03);
        put_w(8'h11, 16'h05FE); put_w(8'h22, 16'h05FF); put_w(8'h33, 16'h0500);
        put(8'h07); put(8'h80); put(8'h00);
        for (int i = 0; i < 256; i++) begin
            put_w(8'(i * 3), 16'h0700 | 16'((32'h80 + i) & 32'hFF));
        end
        put(8'h00); put(8'h01); put(8'h00);
        stop_load("t3", 1'b1, 1'b0);
        check("t3_exec", 32'(bus.exec_addr), 32'h0100);
        verify_writes("t3");

        // Out-of-range segment is dropped with an error; parsing continues
        start_load();
        put(8'h80); put(8'h00); put(8'h01); put(8'h77);
        check("t4_err_oor", 32'(bus.load_err), 32'd1);
        put(8'h01); put(8'h00); put(8'h02);
        put_w(8'hA1, 16'h0100); put_w(8'hA2, 16'h0101);
        put(8'h00); put(8'h01); put(8'h23);
        stop_load("t4", 1'b1, 1'b1);
        check("t4_exec", 32'(bus.exec_addr), 32'h0123);
        verify_writes("t4");

        // Truncated image: fall during DATA
        start_load();
        check("t5_err_clr",   32'(bus.load_err),   32'd0);
        check("t5_valid_clr", 32'(bus.exec_valid), 32'd0);
        put(8'h03); put(8'h00); put(8'h04);
        put_w(8'h01, 16'h0300); put_w(8'h02, 16'h0301);
        stop_load("t5", 1'b0, 1'b1);
        put(8'h03); put(8'h04); put(8'h05);
        verify_writes("t5");

        // Async reset mid-load, while a write is on the port
        start_load();
        put(8'h02); put(8'h00); put(8'h02);
        put_w(8'hAA, 16'h0200);
        check("t6_wren_pre", 32'(bus.ram_wren), 32'd1);
        rst = 1'b1;
        #1;
        check("t6_wren",  32'(bus.ram_wren),   32'd0);
        check("t6_cs",    32'(bus.ram_cs),     32'd0);
        check("t6_hold",  32'(bus.cpu_hold),   32'd0);
        check("t6_addr",  32'(bus.ram_address), 32'd0);
        check("t6_data",  32'(bus.ram_data),   32'd0);
        check("t6_exec",  32'(bus.exec_addr),  32'd0);
        check("t6_valid", 32'(bus.exec_valid), 32'd0);
        check("t6_err",   32'(bus.load_err),   32'd0);
        bus.dl_active = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        verify_writes("t6");

        // Padding after the start address and idle strobes are ignored
        start_load();
        put(8'h03); put(8'h00); put(8'h01);
        put_w(8'h5A, 16'h0300);
        put(8'h00); put(8'h12); put(8'h34);
        for (int i = 0; i < 10; i++) put(8'hFF);
        check("t7_exec_pad", 32'(bus.exec_addr), 32'h1234);
        stop_load("t7", 1'b1, 1'b0);
        put(8'h00); put(8'h99); put(8'h88); put(8'h01); put(8'h02);
        check("t7_exec_idle",  32'(bus.exec_addr),  32'h1234);
        check("t7_valid_idle", 32'(bus.exec_valid), 32'd1);
        check("t7_hold_idle",  32'(bus.cpu_hold),   32'd0);
        verify_writes("t7");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/gt1_loader.md
Name: gt1_loader

Overview:
- Parses a GT1 program image streamed in from the MiSTer HPS download channel and writes its segments into the 32K main RAM through the RAM's write port.
- Sits directly upstream of main RAM; its address, data and write-enable are muxed onto the RAM port while a load is in progress.
- Holds the CPU in reset for the whole load, then publishes the GT1 execution start address.

Parameters:
- ADDR_WIDTH, 15, RAM address width; the writable space is 2**ADDR_WIDTH bytes.
- DATA_WIDTH, 8, RAM data width; fixed at 8 for GT1.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- dl_active  in  1  download in progress (level)
- dl_wr  in  1  one-cycle strobe; dl_data is valid in that cycle
- dl_data  in  8  stream byte
- ram_wren  out  1  RAM write enable, one cycle per byte
- ram_cs  out  1  RAM chip select while loading
- ram_address  out  ADDR_WIDTH  RAM write address
- ram_data  out  DATA_WIDTH  RAM write data
- cpu_hold  out  1  CPU reset request
- exec_addr  out  16  GT1 start address
- exec_valid  out  1  exec_addr valid, sticky until the next load starts
- load_err  out  1  sticky error, cleared when the next load starts

Behaviour:
- Reset (async, active-high): all outputs 0, state IDLE, first_seg=1.
- Byte handshake: one byte is consumed per clock in which dl_wr=1 and dl_active=1. dl_wr is ignored when dl_active=0. There is no backpressure; the block accepts one byte every cycle.
- dl_active rise (registered edge detect):
  - cpu_hold=1, exec_valid=0, load_err=0, first_seg=1.
  - State goes to SEG_HI; the edge cycle itself consumes no byte.
- States and transitions:
  - IDLE.
  - SEG_HI: if byte==0 and first_seg=0, go to START_HI. Otherwise latch hi, go to SEG_LO.
  - SEG_LO: latch lo, go to SEG_SIZE.
  - SEG_SIZE: cnt = byte, where 0 means 256; go to DATA.
  - DATA: write the byte at {hi,lo}. Then lo = lo+1 mod 256 (wraps within the page; hi never changes). cnt-1; when cnt reaches 0, first_seg=0 and go to SEG_HI.
  - START_HI: latch into exec_addr[15:8], go to START_LO.
  - START_LO: latch into exec_addr[7:0], go to DONE.
  - DONE: further bytes are ignored (HPS padding).
- A first segment with hi==0 (zero page) is a legal segment, not a terminator.
- Write timing:
  - A DATA byte consumed in cycle N gives ram_wren=1 in cycle N+1, with ram_address={hi,lo}[ADDR_WIDTH-1:0] and ram_data=byte, all registered.
  - ram_wren is never high two cycles per byte.
  - ram_cs = cpu_hold.
- Range: if {hi,lo} >= 2**ADDR_WIDTH (hi[7]=1 for ADDR_WIDTH=15), the write is suppressed and load_err=1; parsing continues.
- dl_active fall:
  - In DONE: exec_valid=1.
  - In any other state: load_err=1 and exec_valid=0.
  - In both cases the state returns to IDLE and cpu_hold drops on the following cycle, after any pending ram_wren has issued.
- Byte on the same cycle as the fall: the byte is ignored, because dl_active=0 gates it.
- dl_active rise while already loading (no fall seen): treated as a restart.
- Reset mid-load: immediate abort. RAM contents are undefined, cpu_hold=0.

Decomposition:
- Package gt1_pkg:
  - state enum gt1_state_t (IDLE, SEG_HI, SEG_LO, SEG_SIZE, DATA, START_HI, START_LO, DONE)
  - constant GT1_TERMINATOR = 8'h00
  - constant GT1_PAGE_SIZE = 256
- Sub-module gt1_edge_det: registered rise/fall detector on dl_active. Everything else stays in one module.

Test Plan:
- Stream 02 00 03 AA BB CC 00 02 00, then drop dl_active → writes 0x0200=AA, 0x0201=BB, 0x0202=CC on consecutive cycles one cycle after each strobe; exec_addr=0x0200; exec_valid=1; cpu_hold low one cycle after the fall; load_err=0.
- Zero-page first segment: 00 30 01 55 00 08 00 → 0x0030=55, the second 00 acts as terminator, exec_addr=0x0800.
- Page wrap: segment 05 FE size 03 with data 11 22 33 → 0x05FE=11, 0x05FF=22, 0x0500=33. Size byte 00 with 256 bytes → exactly 256 writes, then SEG_HI.
- Out of range: segment 80 00 01 77 → no ram_wren, load_err=1; the following valid segment is still written.
- Truncation: dl_active falls mid-DATA → load_err=1, exec_valid=0, state IDLE. Assert async reset mid-load → all outputs 0 in the same cycle.
- dl_wr pulses with dl_active=0, and 10 padding bytes after START_LO → no writes, exec_addr unchanged.
